// File: rtl/pipe_stage_skid_pkg.sv
// Shared pipeline-stage definitions: state encoding, payload widths, field offsets.
// Used by pipe_stage_skid and the stages that pack/unpack its payload.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_BUSY  = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  localparam int XLEN     = 64;
  localparam int INST_W   = 32;
  localparam int REG_W    = 5;
  localparam int LSTYPE_W = 3;
  localparam int CSR_W    = 12;

  // EX/LS fields, packed LSB first
  localparam int EXLS_CSR_OFF    = 0;
  localparam int EXLS_LSTYPE_OFF = EXLS_CSR_OFF + CSR_W;
  localparam int EXLS_LSV_OFF    = EXLS_LSTYPE_OFF + LSTYPE_W;
  localparam int EXLS_SDATA_OFF  = EXLS_LSV_OFF + 1;
  localparam int EXLS_MADDR_OFF  = EXLS_SDATA_OFF + XLEN;
  localparam int EXLS_WDATA_OFF  = EXLS_MADDR_OFF + XLEN;
  localparam int EXLS_WADDR_OFF  = EXLS_WDATA_OFF + XLEN;
  localparam int EXLS_WE_OFF     = EXLS_WADDR_OFF + REG_W;
  localparam int EXLS_PC_OFF     = EXLS_WE_OFF + 1;
  localparam int EXLS_INST_OFF   = EXLS_PC_OFF + XLEN;

  localparam int IFID_W = INST_W + XLEN;
  localparam int IDEX_W = INST_W + XLEN + 3 * XLEN + REG_W + 1;
  localparam int EXLS_W = EXLS_INST_OFF + INST_W;
  localparam int LSWB_W = INST_W + XLEN + 1 + REG_W + XLEN;

  typedef struct packed {
    logic [INST_W-1:0]   inst;
    logic [XLEN-1:0]     pc;
    logic                we;
    logic [REG_W-1:0]    waddr;
    logic [XLEN-1:0]     wdata;
    logic [XLEN-1:0]     maddr;
    logic [XLEN-1:0]     sdata;
    logic                lsvalid;
    logic [LSTYPE_W-1:0] lstype;
    logic [CSR_W-1:0]    csr;
  } ex_ls_t;

  function automatic logic [1:0] occ_of(pipe_state_e s);
    unique case (s)
      PIPE_BUSY: occ_of = 2'd1;
      PIPE_FULL: occ_of = 2'd2;
      default:   occ_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid.sv
// Valid/ready pipeline register with a 2-entry skid buffer and flush.
// PIPE_BUBBLE_ZERO_EN: zero slots as they empty so bubbles read RESET_VAL.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid_i,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              in_ready_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  input  logic              out_ready_i,
  input  logic              flush_i,
  output logic [1:0]        occupancy_o
);

  pipe_state_e       state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        occ_q;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid_i & in_ready_q;
  assign out_fire = out_valid_q & out_ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      PIPE_EMPTY: begin
        if (in_fire) begin
          state_d = PIPE_BUSY;
          main_d  = in_data_i;
        end
      end
      PIPE_BUSY: begin
        if (in_fire && out_fire) begin
          main_d = in_data_i;
        end else if (in_fire) begin
          state_d = PIPE_FULL;
          skid_d  = in_data_i;
        end else if (out_fire) begin
          state_d = PIPE_EMPTY;
`ifdef PIPE_BUBBLE_ZERO_EN
          main_d  = RESET_VAL;
`else
          main_d  = main_q;
`endif
        end
      end
      PIPE_FULL: begin
        if (out_fire) begin
          state_d = PIPE_BUSY;
          main_d  = skid_q;
`ifdef PIPE_BUBBLE_ZERO_EN
          skid_d  = RESET_VAL;
`else
          skid_d  = skid_q;
`endif
        end
      end
      default: begin
        state_d = PIPE_EMPTY;
      end
    endcase
    // flush wins over any same-cycle accept
    if (flush_i) begin
      state_d = PIPE_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PIPE_EMPTY;
      main_q      <= RESET_VAL;
      skid_q      <= RESET_VAL;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= (state_d != PIPE_FULL);
      out_valid_q <= (state_d != PIPE_EMPTY);
      occ_q       <= occ_of(state_d);
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = main_q;
  assign occupancy_o = occ_q;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid (DATA_W=32) against a queue-based model.
// Define PIPE_BUBBLE_ZERO_EN to check the zeroed-bubble build.
module tb_pipe_stage_skid;

`ifdef PIPE_BUBBLE_ZERO_EN
  localparam bit BZ = 1'b1;
`else
  localparam bit BZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_i = 1'b0;
  logic [31:0] in_data_i = '0;
  logic        in_ready_o;
  logic        out_valid_o;
  logic [31:0] out_data_o;
  logic        out_ready_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  occupancy_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0] q[$];
  logic [31:0] empty_data = '0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(32), .RESET_VAL(32'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid_i),
    .in_data_i  (in_data_i),
    .in_ready_o (in_ready_o),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_ready_i(out_ready_i),
    .flush_i    (flush_i),
    .occupancy_o(occupancy_o)
  );

  // One cycle: drive, clock, advance the FIFO model, settle 1 time unit.
  task automatic cyc(input logic v, input logic [31:0] d,
                     input logic r, input logic f);
    logic inf, outf;
    logic [31:0] popped;
    in_valid_i  = v;
    in_data_i   = d;
    out_ready_i = r;
    flush_i     = f;
    inf  = v && (q.size() < 2);
    outf = r && (q.size() > 0);
    @(posedge clk);
    if (f) begin
      q.delete();
      empty_data = '0;
    end else begin
      if (outf) begin
        popped = q.pop_front();
        if (q.size() == 0 && !inf)
          empty_data = BZ ? 32'h0 : popped;
      end
      if (inf) q.push_back(d);
    end
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (out_valid_o !== 1'b0) $display("FAIL reset_valid got %0b exp 0", out_valid_o);
    else pass_cnt++;
    total_cnt++;
    if (in_ready_o !== 1'b1) $display("FAIL reset_ready got %0b exp 1", in_ready_o);
    else pass_cnt++;
    total_cnt++;
    if (occupancy_o !== 2'd0) $display("FAIL reset_occ got %0d exp 0", occupancy_o);
    else pass_cnt++;
    total_cnt++;
    if (out_data_o !== 32'h0) $display("FAIL reset_data got %h exp 0", out_data_o);
    else pass_cnt++;
    rst_n = 1'b1;
    q.delete();
    empty_data = '0;
    cyc(1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic test_streaming;
    logic [31:0] vals [3];
    vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, vals[i], 1'b1, 1'b0);
      total_cnt++;
      if (out_valid_o !== 1'b1 || out_data_o !== vals[i])
        $display("FAIL stream_out%0d got v=%0b d=%h exp v=1 d=%h",
                 i, out_valid_o, out_data_o, vals[i]);
      else pass_cnt++;
      total_cnt++;
      if (in_ready_o !== 1'b1) $display("FAIL stream_ready%0d got %0b exp 1", i, in_ready_o);
      else pass_cnt++;
    end
    cyc(1'b0, '0, 1'b1, 1'b0);
    total_cnt++;
    if (out_valid_o !== 1'b0) $display("FAIL stream_drain got %0b exp 0", out_valid_o);
    else pass_cnt++;
  endtask

  task automatic test_skid;
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    total_cnt++;
    if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0)
      $display("FAIL skid_full got occ=%0d rdy=%0b exp occ=2 rdy=0", occupancy_o, in_ready_o);
    else pass_cnt++;
    total_cnt++;
    if (out_data_o !== 32'hA) $display("FAIL skid_head got %h exp a", out_data_o);
    else pass_cnt++;
    cyc(1'b0, '0, 1'b1, 1'b0);
    total_cnt++;
    if (out_valid_o !== 1'b1 || out_data_o !== 32'hB || in_ready_o !== 1'b1)
      $display("FAIL skid_second got v=%0b d=%h rdy=%0b exp v=1 d=b rdy=1",
               out_valid_o, out_data_o, in_ready_o);
    else pass_cnt++;
    cyc(1'b0, '0, 1'b1, 1'b0);
    total_cnt++;
    if (out_valid_o !== 1'b0 || occupancy_o !== 2'd0)
      $display("FAIL skid_empty got v=%0b occ=%0d exp v=0 occ=0", out_valid_o, occupancy_o);
    else pass_cnt++;
  endtask

  task automatic test_flush_full;
    cyc(1'b1, 32'hA, 1'b0, 1'b0);
    cyc(1'b1, 32'hB, 1'b0, 1'b0);
    cyc(1'b1, 32'hC, 1'b0, 1'b1);
    total_cnt++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1)
      $display("FAIL flush_state got occ=%0d v=%0b rdy=%0b exp occ=0 v=0 rdy=1",
               occupancy_o, out_valid_o, in_ready_o);
    else pass_cnt++;
    total_cnt++;
    if (out_data_o !== 32'h0) $display("FAIL flush_data got %h exp 0", out_data_o);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1, 1'b0);
      total_cnt++;
      if (out_valid_o !== 1'b0)
        $display("FAIL flush_no_emit%0d got v=%0b d=%h exp v=0", i, out_valid_o, out_data_o);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back;
    cyc(1'b1, 32'h5, 1'b0, 1'b0);
    total_cnt++;
    if (out_data_o !== 32'h5 || occupancy_o !== 2'd1)
      $display("FAIL b2b_hold got d=%h occ=%0d exp d=5 occ=1", out_data_o, occupancy_o);
    else pass_cnt++;
    cyc(1'b1, 32'h6, 1'b1, 1'b0);
    total_cnt++;
    if (out_data_o !== 32'h6 || occupancy_o !== 2'd1 || out_valid_o !== 1'b1)
      $display("FAIL b2b_swap got d=%h occ=%0d v=%0b exp d=6 occ=1 v=1",
               out_data_o, occupancy_o, out_valid_o);
    else pass_cnt++;
    cyc(1'b0, '0, 1'b1, 1'b0);
  endtask

  task automatic test_async_reset;
    cyc(1'b1, 32'h77, 1'b0, 1'b0);
    cyc(1'b1, 32'h88, 1'b0, 1'b0);
    in_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (out_valid_o !== 1'b0 || in_ready_o !== 1'b1 || occupancy_o !== 2'd0 ||
        out_data_o !== 32'h0)
      $display("FAIL async_rst got v=%0b rdy=%0b occ=%0d d=%h exp v=0 rdy=1 occ=0 d=0",
               out_valid_o, in_ready_o, occupancy_o, out_data_o);
    else pass_cnt++;
    q.delete();
    empty_data = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random;
    logic        v, r, f, pend;
    logic [31:0] d;
    logic [31:0] exp_d;
    pend = 1'b0;
    v = 1'b0;
    d = '0;
    for (int i = 0; i < 500; i++) begin
      if (!pend) begin
        v = ($urandom_range(0, 3) != 0);
        d = $urandom();
      end
      r = ($urandom_range(0, 2) != 0);
      f = ($urandom_range(0, 24) == 0);
      pend = v && (q.size() >= 2) && !f;
      cyc(v, d, r, f);
      exp_d = (q.size() > 0) ? q[0] : empty_data;
      total_cnt++;
      if (out_valid_o !== (q.size() > 0) || occupancy_o !== 2'(q.size()) ||
          in_ready_o !== (q.size() < 2) || out_data_o !== exp_d) begin
        $display("FAIL rand%0d got v=%0b occ=%0d rdy=%0b d=%h exp v=%0b occ=%0d rdy=%0b d=%h",
                 i, out_valid_o, occupancy_o, in_ready_o, out_data_o,
                 q.size() > 0, q.size(), q.size() < 2, exp_d);
      end else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_skid();
    test_flush_full();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
